// File: rtl/ctrl_pkg.sv
// Shared opcode constants, ALUop encodings and the bundled control word for the
// single-cycle MIPS main control decoder.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  typedef struct packed {
    logic       rtype;
    logic       lw;
    logic       sw;
    logic       jump;
    logic       branch;
    logic       addi;
    logic       RegDst;
    logic       ALUSrc;
    logic       RegWrite;
    logic       Mem2Reg;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUop;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/opcode_decode.sv
// Exact-match opcode classifier: one-hot class flags, or illegal when none match.
module opcode_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opCode,
  output logic       rtype,
  output logic       lw,
  output logic       sw,
  output logic       jump,
  output logic       branch,
  output logic       addi,
  output logic       illegal
);

  assign rtype   = (opCode == OP_RTYPE);
  assign lw      = (opCode == OP_LW);
  assign sw      = (opCode == OP_SW);
  assign jump    = (opCode == OP_J);
  assign branch  = (opCode == OP_BEQ);
  assign addi    = (opCode == OP_ADDI);
  assign illegal = ~|{rtype, lw, sw, jump, branch, addi};

endmodule

// File: rtl/main_control.sv
// Main control decoder: opcode classes, datapath controls and ALUop, with an
// optional output register selected by REGISTERED.
module main_control
  import ctrl_pkg::*;
#(
  parameter int unsigned REGISTERED = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opCode,
  output logic       rtype,
  output logic       lw,
  output logic       sw,
  output logic       jump,
  output logic       branch,
  output logic       addi,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Mem2Reg,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] ALUop,
  output logic       illegal
);

  logic  w_rtype, w_lw, w_sw, w_jump, w_branch, w_addi, w_illegal;
  ctrl_t w_ctrl;
  ctrl_t w_out;

  opcode_decode u_decode (
    .opCode  (opCode),
    .rtype   (w_rtype),
    .lw      (w_lw),
    .sw      (w_sw),
    .jump    (w_jump),
    .branch  (w_branch),
    .addi    (w_addi),
    .illegal (w_illegal)
  );

  // Illegal opcodes leave every enable low, so they retire as a NOP.
  always_comb begin
    w_ctrl          = '0;
    w_ctrl.rtype    = w_rtype;
    w_ctrl.lw       = w_lw;
    w_ctrl.sw       = w_sw;
    w_ctrl.jump     = w_jump;
    w_ctrl.branch   = w_branch;
    w_ctrl.addi     = w_addi;
    w_ctrl.RegDst   = w_rtype;
    w_ctrl.ALUSrc   = w_lw | w_sw | w_addi;
    w_ctrl.RegWrite = w_rtype | w_lw | w_addi;
    w_ctrl.Mem2Reg  = w_lw;
    w_ctrl.MemRead  = w_lw;
    w_ctrl.MemWrite = w_sw;
    w_ctrl.ALUop    = {w_rtype, w_branch};
    w_ctrl.illegal  = w_illegal;
  end

  generate
    if (REGISTERED != 0) begin : g_reg
      ctrl_t r_ctrl;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ctrl <= '0;
        else     r_ctrl <= w_ctrl;
      end

      assign w_out = r_ctrl;
    end else begin : g_comb
      // Clock has no role in the combinational build.
      logic w_unused_clk;
      assign w_unused_clk = clk;
      assign w_out = rst ? '0 : w_ctrl;
    end
  endgenerate

  assign rtype    = w_out.rtype;
  assign lw       = w_out.lw;
  assign sw       = w_out.sw;
  assign jump     = w_out.jump;
  assign branch   = w_out.branch;
  assign addi     = w_out.addi;
  assign RegDst   = w_out.RegDst;
  assign ALUSrc   = w_out.ALUSrc;
  assign RegWrite = w_out.RegWrite;
  assign Mem2Reg  = w_out.Mem2Reg;
  assign MemRead  = w_out.MemRead;
  assign MemWrite = w_out.MemWrite;
  assign ALUop    = w_out.ALUop;
  assign illegal  = w_out.illegal;

endmodule

// File: tb/tb_main_control.sv
// Directed bench for main_control: combinational and registered builds side by side.
module tb_main_control;

  logic       clk;
  logic       rst;
  logic [5:0] opCode;

  logic       c_rtype, c_lw, c_sw, c_jump, c_branch, c_addi;
  logic       c_RegDst, c_ALUSrc, c_RegWrite, c_Mem2Reg, c_MemRead, c_MemWrite, c_illegal;
  logic [1:0] c_ALUop;
  logic       r_rtype, r_lw, r_sw, r_jump, r_branch, r_addi;
  logic       r_RegDst, r_ALUSrc, r_RegWrite, r_Mem2Reg, r_MemRead, r_MemWrite, r_illegal;
  logic [1:0] r_ALUop;

  logic [14:0] c_vec, r_vec;
  int          n_checks;
  int          n_fail;

  main_control #(.REGISTERED(0)) dut_c (
    .clk(clk), .rst(rst), .opCode(opCode),
    .rtype(c_rtype), .lw(c_lw), .sw(c_sw), .jump(c_jump), .branch(c_branch), .addi(c_addi),
    .RegDst(c_RegDst), .ALUSrc(c_ALUSrc), .RegWrite(c_RegWrite), .Mem2Reg(c_Mem2Reg),
    .MemRead(c_MemRead), .MemWrite(c_MemWrite), .ALUop(c_ALUop), .illegal(c_illegal)
  );

  main_control #(.REGISTERED(1)) dut_r (
    .clk(clk), .rst(rst), .opCode(opCode),
    .rtype(r_rtype), .lw(r_lw), .sw(r_sw), .jump(r_jump), .branch(r_branch), .addi(r_addi),
    .RegDst(r_RegDst), .ALUSrc(r_ALUSrc), .RegWrite(r_RegWrite), .Mem2Reg(r_Mem2Reg),
    .MemRead(r_MemRead), .MemWrite(r_MemWrite), .ALUop(r_ALUop), .illegal(r_illegal)
  );

  // {rtype,lw,sw,jump,branch,addi,RegDst,ALUSrc,RegWrite,Mem2Reg,MemRead,MemWrite,ALUop,illegal}
  assign c_vec = {c_rtype, c_lw, c_sw, c_jump, c_branch, c_addi, c_RegDst, c_ALUSrc,
                  c_RegWrite, c_Mem2Reg, c_MemRead, c_MemWrite, c_ALUop, c_illegal};
  assign r_vec = {r_rtype, r_lw, r_sw, r_jump, r_branch, r_addi, r_RegDst, r_ALUSrc,
                  r_RegWrite, r_Mem2Reg, r_MemRead, r_MemWrite, r_ALUop, r_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] exp_vec(input logic [5:0] op);
    case (op)
      6'h00:   return 15'b1_0_0_0_0_0_1_0_1_0_0_0_10_0;
      6'h23:   return 15'b0_1_0_0_0_0_0_1_1_1_1_0_00_0;
      6'h2B:   return 15'b0_0_1_0_0_0_0_1_0_0_0_1_00_0;
      6'h02:   return 15'b0_0_0_1_0_0_0_0_0_0_0_0_00_0;
      6'h04:   return 15'b0_0_0_0_1_0_0_0_0_0_0_0_01_0;
      6'h08:   return 15'b0_0_0_0_0_1_0_1_1_0_0_0_00_0;
      default: return 15'b0_0_0_0_0_0_0_0_0_0_0_0_00_1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  initial begin
    logic [5:0] dir_ops [7];
    n_checks = 0;
    n_fail   = 0;
    dir_ops  = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h02, 6'h3F};

    rst    = 1'b1;
    opCode = 6'h3F;
    #1;
    chk("comb_rst_illegal_op", c_vec, 15'd0);
    chk("reg_rst", r_vec, 15'd0);
    opCode = 6'h00;
    #1;
    chk("comb_rst_rtype_op", c_vec, 15'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      opCode = dir_ops[i];
      #1;
      chk($sformatf("comb_op_%02h", dir_ops[i]), c_vec, exp_vec(dir_ops[i]));
    end

    for (int op = 0; op < 64; op++) begin
      opCode = 6'(op);
      #1;
      chk($sformatf("sweep_%02h", op), c_vec, exp_vec(6'(op)));
    end

    // Registered build: one-cycle latency, async clear, resume after release.
    @(negedge clk);
    opCode = 6'h3F;
    @(posedge clk); #1;
    chk("reg_illegal", r_vec, exp_vec(6'h3F));
    @(negedge clk);
    opCode = 6'h23;
    #1;
    chk("reg_lw_before_edge", r_vec, exp_vec(6'h3F));
    @(posedge clk); #1;
    chk("reg_lw_after_edge", r_vec, exp_vec(6'h23));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("reg_async_clear", r_vec, 15'd0);
    chk("comb_async_clear", c_vec, 15'd0);
    @(posedge clk); #1;
    chk("reg_held_in_rst", r_vec, 15'd0);
    @(negedge clk);
    rst    = 1'b0;
    opCode = 6'h2B;
    #1;
    chk("reg_after_release", r_vec, 15'd0);
    chk("comb_after_release", c_vec, exp_vec(6'h2B));
    @(posedge clk); #1;
    chk("reg_resume_sw", r_vec, exp_vec(6'h2B));
    @(negedge clk);
    opCode = 6'h04;
    @(posedge clk); #1;
    chk("reg_beq", r_vec, exp_vec(6'h04));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
